// File: rtl/debounce_filter_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_filter_multi_pkg
//  Purpose  : Shared constants and helper function for the debounce filter
//  Revision : 1.0  initial release
// ============================================================================
package debounce_filter_multi_pkg;

  localparam int FLT_STABLE_CNT  = 4;
  localparam int FLT_SYNC_STAGES = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_filter_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : One filter channel: synchroniser, stability counter, level and
//             registered rise/fall pulse outputs
//  Revision : 1.0  initial release
// ============================================================================
module debounce_channel
  import debounce_filter_multi_pkg::*;
#(
  parameter int   STABLE_CNT  = FLT_STABLE_CNT,
  parameter int   SYNC_STAGES = FLT_SYNC_STAGES,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_sig,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall
);

  localparam int               CNT_W      = clog2(STABLE_CNT) + 1;
  localparam logic [CNT_W-1:0] c_term_cnt = CNT_W'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_s;
  logic                   w_diff;
  logic                   w_term;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_diff = (w_s != r_out);
  assign w_term = (r_cnt == c_term_cnt);

  // The synchroniser keeps shifting even while filtering is paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_out  <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_enable) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_term) begin
          r_out  <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_sig  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/debounce_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_filter_multi
//  Purpose  : Multi-channel debounce filter; replicates independent channels
//             and merges their edge pulses into a single change flag
//  Revision : 1.0  initial release
// ============================================================================
module debounce_filter_multi
  import debounce_filter_multi_pkg::*;
#(
  parameter int   CHANNELS    = 4,
  parameter int   STABLE_CNT  = FLT_STABLE_CNT,
  parameter int   SYNC_STAGES = FLT_SYNC_STAGES,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic [CHANNELS-1:0] i_sig_in,
  output logic [CHANNELS-1:0] o_sig_out,
  output logic [CHANNELS-1:0] o_rise,
  output logic [CHANNELS-1:0] o_fall,
  output logic                o_any_change
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT  (STABLE_CNT),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (RESET_VAL)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .i_enable (i_enable),
      .i_sig    (i_sig_in[gi]),
      .o_sig    (o_sig_out[gi]),
      .o_rise   (o_rise[gi]),
      .o_fall   (o_fall[gi])
    );
  end

  // Pulses are already registered, so the flag lines up with them exactly.
  assign o_any_change = |(o_rise | o_fall);

endmodule
`default_nettype wire

// File: tb/tb_debounce_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_filter_multi
//  Purpose  : Directed self-checking bench for debounce_filter_multi
//  Revision : 1.0  initial release
// ============================================================================
module tb_debounce_filter_multi;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] sin;
  logic [3:0] o_out, o_rise, o_fall;
  logic       o_any;
  logic [3:0] o5_out, o5_rise, o5_fall;
  logic       o5_any;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  debounce_filter_multi #(.CHANNELS(4), .STABLE_CNT(4), .SYNC_STAGES(2), .RESET_VAL(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (en),
    .i_sig_in     (sin),
    .o_sig_out    (o_out),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_any_change (o_any)
  );

  debounce_filter_multi #(.CHANNELS(4), .STABLE_CNT(5), .SYNC_STAGES(2), .RESET_VAL(1'b0)) dut5 (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (en),
    .i_sig_in     (sin),
    .o_sig_out    (o5_out),
    .o_rise       (o5_rise),
    .o_fall       (o5_fall),
    .o_any_change (o5_any)
  );

  task automatic chk(input string name, input int j, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %b expected %b", name, j, act, exp);
    end
  endtask

  task automatic apply(input string tag, input int j, input logic r, input logic e,
                       input logic [3:0] in, input logic [3:0] out,
                       input logic [3:0] rise, input logic [3:0] fall, input logic any);
    rst = r;
    en  = e;
    sin = in;
    @(posedge clk);
    #1;
    chk({tag, " sig_out"}, j, o_out, out);
    chk({tag, " rise"}, j, o_rise, rise);
    chk({tag, " fall"}, j, o_fall, fall);
    chk({tag, " any_change"}, j, {3'b000, o_any}, {3'b000, any});
  endtask

  task automatic do_reset(input string tag);
    for (int k = 0; k < 2; k++) apply(tag, k, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    en  = 1'b1;
    sin = 4'h0;

    // Reset held for 6 cycles, then a 4-high/4-low square wave on ch0.
    // With STABLE_CNT=4 the output is the input delayed by 5 edges.
    for (int i = 0; i < 6; i++) begin
      v.rst = 1'b1; v.en = 1'b1; v.in = 4'h0;
      v.out = 4'h0; v.rise = 4'h0; v.fall = 4'h0; v.any = 1'b0;
      tbl.push_back(v);
    end
    for (int j = 0; j < 20; j++) begin
      v.rst  = 1'b0;
      v.en   = 1'b1;
      v.in   = {3'b000, (j < 16) && ((j % 8) < 4)};
      v.out  = {3'b000, (j >= 5) && (((j - 5) % 8) < 4)};
      v.rise = {3'b000, (j == 5) || (j == 13)};
      v.fall = {3'b000, (j == 9) || (j == 17)};
      v.any  = (j == 5) || (j == 13) || (j == 9) || (j == 17);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      apply("square", i, tbl[i].rst, tbl[i].en, tbl[i].in, tbl[i].out,
            tbl[i].rise, tbl[i].fall, tbl[i].any);
      // Four-cycle pulses never satisfy a five-cycle stability window.
      chk("cnt5 sig_out", i, o5_out, 4'h0);
      chk("cnt5 rise", i, o5_rise, 4'h0);
      chk("cnt5 fall", i, o5_fall, 4'h0);
      chk("cnt5 any_change", i, {3'b000, o5_any}, 4'h0);
    end

    // Glitch on ch1: 3 high, 1 low, then high; rise 5 edges after the last rise.
    do_reset("rst_a");
    for (int j = 0; j < 12; j++) begin
      apply("glitch", j, 1'b0, 1'b1,
            (j != 3) ? 4'b0010 : 4'b0000,
            (j >= 9) ? 4'b0010 : 4'b0000,
            (j == 9) ? 4'b0010 : 4'b0000,
            4'b0000, (j == 9));
    end

    // ch2 held high, enable low for 3 edges after 2 counted: rise slips 3 edges.
    do_reset("rst_b");
    for (int j = 0; j < 11; j++) begin
      apply("enable", j, 1'b0, !((j >= 4) && (j <= 6)), 4'b0100,
            (j >= 8) ? 4'b0100 : 4'b0000,
            (j == 8) ? 4'b0100 : 4'b0000,
            4'b0000, (j == 8));
    end

    // Reset mid-count on ch3, then all channels rise together.
    do_reset("rst_c");
    for (int j = 0; j < 15; j++) begin
      apply("midreset", j, (j == 4) || (j == 5), 1'b1,
            (j < 4) ? 4'b1000 : ((j < 6) ? 4'b0000 : 4'b1111),
            (j >= 11) ? 4'b1111 : 4'b0000,
            (j == 11) ? 4'b1111 : 4'b0000,
            4'b0000, (j == 11));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
